uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_sync.sv | 35 +++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, receiver state encoding and parity helper.
// UART_RX_PARITY_EN adds the PARITY state used by the 8E1 receiver build.
package uart_pkg;

   localparam int BAUD_DIV_DEFAULT = 5208;
   localparam int BAUD_DIV_SIM     = 29;
   localparam int DATA_W           = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } rx_state_e;

   // Even-parity bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_W-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector.
// The edge output stays quiet until the chain holds real line samples after reset.
module uart_rx_sync (
   input  logic sclk,
   input  logic srst,
   input  logic rs232_rx,
   output logic line_sync,
   output logic line_fall
);

   logic       sync1_r;
   logic       sync2_r;
   logic       prev_r;
   logic [2:0] arm_r;

   // Synchronizer chain, previous-sample flop and post-reset arming shift.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         sync1_r <= 1'b1;
         sync2_r <= 1'b1;
         prev_r  <= 1'b1;
         arm_r   <= 3'b000;
      end else begin
         sync1_r <= rs232_rx;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
         arm_r   <= {arm_r[1:0], 1'b1};
      end
   end

   assign line_sync = sync2_r;
   // A line already low at reset release must not look like a fresh start edge.
   assign line_fall = arm_r[2] & prev_r & ~sync2_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; defining UART_RX_PARITY_EN selects 8E1.
// Samples each bit at its midpoint and reports data, framing and parity results.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic              sclk,
   input  logic              srst,
   input  logic              rs232_rx,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              rx_busy,
   output logic              rx_frame_err,
   output logic              rx_parity_err
);

   localparam int              CNT_W    = $clog2(BAUD_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2);

   rx_state_e         state_r;
   rx_state_e         state_next_s;
   logic              line_sync_s;
   logic              line_fall_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [2:0]        bit_cnt_r;
   logic [DATA_W-1:0] shift_r;
   logic              sample_s;
   logic              par_err_s;
   logic              valid_set_s;
   logic              ferr_set_s;
   logic              perr_set_s;
   logic              busy_next_s;
   logic [DATA_W-1:0] rx_data_r;
   logic              rx_valid_r;
   logic              rx_busy_r;
   logic              rx_frame_err_r;
   logic              rx_parity_err_r;

   uart_rx_sync u_sync (
      .sclk      (sclk),
      .srst      (srst),
      .rs232_rx  (rs232_rx),
      .line_sync (line_sync_s),
      .line_fall (line_fall_s)
   );

   assign sample_s = (cnt_r == CNT_MID);

   // FSM state register.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; STOP returns to IDLE at its sample to resync on the next edge.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (line_fall_s) state_next_s = ST_START;
            else             state_next_s = ST_IDLE;
         end
         ST_START: begin
            if (sample_s) begin
               if (line_sync_s) state_next_s = ST_IDLE;
               else             state_next_s = ST_DATA;
            end else begin
               state_next_s = ST_START;
            end
         end
         ST_DATA: begin
            if (sample_s && (bit_cnt_r == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
               state_next_s = ST_PARITY;
`else
               state_next_s = ST_STOP;
`endif
            end else begin
               state_next_s = ST_DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (sample_s) state_next_s = ST_STOP;
            else          state_next_s = ST_PARITY;
         end
`endif
         ST_STOP: begin
            if (sample_s) state_next_s = ST_IDLE;
            else          state_next_s = ST_STOP;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FSM output decode; a framing error outranks a parity error.
   always_comb begin
      valid_set_s = 1'b0;
      ferr_set_s  = 1'b0;
      perr_set_s  = 1'b0;
      busy_next_s = (state_next_s != ST_IDLE);
      if ((state_r == ST_STOP) && sample_s) begin
         if (!line_sync_s)   ferr_set_s  = 1'b1;
         else if (par_err_s) perr_set_s  = 1'b1;
         else                valid_set_s = 1'b1;
      end else begin
         valid_set_s = 1'b0;
      end
   end

   // Baud counter, bit counter and data shift register.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         cnt_r     <= {CNT_W{1'b0}};
         bit_cnt_r <= 3'd0;
         shift_r   <= {DATA_W{1'b0}};
      end else begin
         if (state_r == ST_IDLE)  cnt_r <= {CNT_W{1'b0}};
         else if (cnt_r == CNT_LAST) cnt_r <= {CNT_W{1'b0}};
         else                     cnt_r <= cnt_r + CNT_W'(1);
         if ((state_r == ST_DATA) && sample_s) begin
            bit_cnt_r <= bit_cnt_r + 3'd1;
            shift_r   <= {line_sync_s, shift_r[DATA_W-1:1]};
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_err_r;

   // Parity check captured at the parity-bit midpoint.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         par_err_r <= 1'b0;
      end else if ((state_r == ST_PARITY) && sample_s) begin
         par_err_r <= even_parity(shift_r) ^ line_sync_s;
      end
   end

   assign par_err_s = par_err_r;
`else
   assign par_err_s = 1'b0;
`endif

   // Registered outputs; rx_data only moves on a clean frame.
   always_ff @(posedge sclk or negedge srst) begin
      if (!srst) begin
         rx_data_r       <= {DATA_W{1'b0}};
         rx_valid_r      <= 1'b0;
         rx_busy_r       <= 1'b0;
         rx_frame_err_r  <= 1'b0;
         rx_parity_err_r <= 1'b0;
      end else begin
         if (valid_set_s) rx_data_r <= shift_r;
         rx_valid_r      <= valid_set_s;
         rx_busy_r       <= busy_next_s;
         rx_frame_err_r  <= ferr_set_s;
         rx_parity_err_r <= perr_set_s;
      end
   end

   assign rx_data       = rx_data_r;
   assign rx_valid      = rx_valid_r;
   assign rx_busy       = rx_busy_r;
   assign rx_frame_err  = rx_frame_err_r;
   assign rx_parity_err = rx_parity_err_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at BAUD_DIV=29; parity frames follow UART_RX_PARITY_EN.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int BAUD = BAUD_DIV_SIM;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 308;
`else
   localparam int LAT = 279;
`endif

   logic       sclk = 1'b0;
   logic       srst = 1'b1;
   logic       rs232_rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_parity_err;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   int excl_err = 0;
   int valid_cyc = 0;
   int fall_cyc = 0;
   logic any_prev = 1'b0;
   logic [7:0] rxq[$];

   uart_rx #(.BAUD_DIV(BAUD)) dut (
      .sclk          (sclk),
      .srst          (srst),
      .rs232_rx      (rs232_rx),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_busy       (rx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err)
   );

   always #5 sclk = ~sclk;

   always @(posedge sclk) cyc <= cyc + 1;

   // Pulse monitor: counts each result pulse and flags overlapping or adjacent pulses.
   always @(negedge sclk) begin
      if (rx_valid === 1'b1) begin
         valid_cnt <= valid_cnt + 1;
         valid_cyc <= cyc;
         rxq.push_back(rx_data);
      end
      if (rx_frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
      if (rx_parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
      if ((int'(rx_valid === 1'b1) + int'(rx_frame_err === 1'b1) + int'(rx_parity_err === 1'b1) > 1) ||
          (any_prev && ((rx_valid | rx_frame_err | rx_parity_err) === 1'b1)))
         excl_err <= excl_err + 1;
      any_prev <= ((rx_valid | rx_frame_err | rx_parity_err) === 1'b1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_bit(input logic b);
      rs232_rx = b;
      repeat (BAUD) @(negedge sclk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_b, input logic chk_busy);
      fall_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(d[i]);
         if (chk_busy && (i == 0)) chk("busy_mid_frame", 32'(rx_busy), 32'd1);
      end
`ifdef UART_RX_PARITY_EN
      drive_bit((^d) ^ par_flip);
`endif
      drive_bit(stop_b);
   endtask

   int v0, f0, p0, n0;

   initial begin
      #2 srst = 1'b0;
      repeat (3) @(negedge sclk);
      chk("rst_data", 32'(rx_data), 32'h00);
      chk("rst_valid", 32'(rx_valid), 32'd0);
      chk("rst_busy", 32'(rx_busy), 32'd0);
      chk("rst_ferr", 32'(rx_frame_err), 32'd0);
      chk("rst_perr", 32'(rx_parity_err), 32'd0);
      srst = 1'b1;
      repeat (5) @(negedge sclk);

      // 0xA5 with latency measurement
      v0 = valid_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
      chk("a5_valid_count", 32'(valid_cnt), 32'(v0 + 1));
      chk("a5_data", 32'(rx_data), 32'hA5);
      chk("a5_latency", 32'(valid_cyc - fall_cyc), 32'(LAT));
      chk("a5_busy_after", 32'(rx_busy), 32'd0);
      repeat (BAUD) @(negedge sclk);

      // short low glitch, then 0x3C
      v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      rs232_rx = 1'b0;
      repeat (5) @(negedge sclk);
      rs232_rx = 1'b1;
      repeat (2 * BAUD) @(negedge sclk);
      chk("glitch_valid", 32'(valid_cnt), 32'(v0));
      chk("glitch_ferr", 32'(ferr_cnt), 32'(f0));
      chk("glitch_perr", 32'(perr_cnt), 32'(p0));
      chk("glitch_busy", 32'(rx_busy), 32'd0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
      chk("3c_valid_count", 32'(valid_cnt), 32'(v0 + 1));
      chk("3c_data", 32'(rx_data), 32'h3C);
      repeat (BAUD) @(negedge sclk);

      // 0x5A with low stop bit, then a long break
      v0 = valid_cnt; f0 = ferr_cnt;
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      repeat (20 * BAUD) @(negedge sclk);
      rs232_rx = 1'b1;
      repeat (3 * BAUD) @(negedge sclk);
      chk("break_ferr_count", 32'(ferr_cnt), 32'(f0 + 1));
      chk("break_valid_count", 32'(valid_cnt), 32'(v0));
      chk("break_data_hold", 32'(rx_data), 32'h3C);

      // back-to-back frames with no idle gap
      n0 = rxq.size();
      send_frame(8'h00, 1'b0, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, 1'b0);
      repeat (2 * BAUD) @(negedge sclk);
      chk("b2b_count", 32'(rxq.size()), 32'(n0 + 3));
      if (rxq.size() >= n0 + 3) begin
         chk("b2b_first", 32'(rxq[n0]), 32'h00);
         chk("b2b_second", 32'(rxq[n0 + 1]), 32'hFF);
         chk("b2b_third", 32'(rxq[n0 + 2]), 32'h81);
      end

      // reset during bit 4 of 0xC3, release during bit 5 while the line is low
      v0 = valid_cnt; f0 = ferr_cnt; p0 = perr_cnt;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b0);
      rs232_rx = 1'b0;
      repeat (10) @(negedge sclk);
      srst = 1'b0;
      #1;
      chk("midrst_data", 32'(rx_data), 32'h00);
      chk("midrst_busy", 32'(rx_busy), 32'd0);
      repeat (19) @(negedge sclk);
      rs232_rx = 1'b0;
      repeat (10) @(negedge sclk);
      srst = 1'b1;
      repeat (19) @(negedge sclk);
      drive_bit(1'b1);
      drive_bit(1'b1);
`ifdef UART_RX_PARITY_EN
      drive_bit(1'b0);
`endif
      drive_bit(1'b1);
      repeat (2 * BAUD) @(negedge sclk);
      chk("c3_no_valid", 32'(valid_cnt), 32'(v0));
      chk("c3_no_ferr", 32'(ferr_cnt), 32'(f0));
      chk("c3_no_perr", 32'(perr_cnt), 32'(p0));
      chk("c3_busy", 32'(rx_busy), 32'd0);
      send_frame(8'h11, 1'b0, 1'b1, 1'b0);
      chk("11_valid_count", 32'(valid_cnt), 32'(v0 + 1));
      chk("11_data", 32'(rx_data), 32'h11);
      repeat (BAUD) @(negedge sclk);

`ifdef UART_RX_PARITY_EN
      // 0x07 with correct parity, then with wrong parity
      v0 = valid_cnt; p0 = perr_cnt;
      send_frame(8'h07, 1'b0, 1'b1, 1'b0);
      chk("par_ok_valid", 32'(valid_cnt), 32'(v0 + 1));
      chk("par_ok_data", 32'(rx_data), 32'h07);
      repeat (BAUD) @(negedge sclk);
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      repeat (BAUD) @(negedge sclk);
      chk("par_bad_perr", 32'(perr_cnt), 32'(p0 + 1));
      chk("par_bad_valid", 32'(valid_cnt), 32'(v0 + 1));
      chk("par_bad_data", 32'(rx_data), 32'h07);
`endif

      chk("pulse_exclusive", 32'(excl_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
